// File: rtl/img_pkg.sv
// Shared types and default widths for the image RAM writer path.
package img_pkg;
   typedef enum logic {IDLE, LOAD} state_t;

   localparam int IMG_ADDR_W = 14;
   localparam int IMG_DATA_W = 8;
   localparam logic [7:0] IMG_SYNC = 8'hAA;
endpackage

// File: rtl/byte_timeout.sv
// Idle-gap counter: clr restarts it, en counts; expired is a combinational strobe on the
// TimeoutCycles-th consecutive enabled cycle. The count saturates and never wraps.
module byte_timeout #(
   parameter int TimeoutCycles = 12000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CW-1:0] LAST = CW'(TimeoutCycles - 1);

   logic [CW-1:0] count;

   assign expired = en && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && count != LAST) begin
         count <= count + CW'(1);
      end
   end
endmodule

// File: rtl/img_ram_loader.sv
// Fills the image RAM from a sync-prefixed UART byte stream; each write reaches the port 1 clk after rx_valid.
// No backpressure: a write steals the port from the VGA read address for that cycle only.
module img_ram_loader
   import img_pkg::*;
#(
   parameter int                    AddressWidth  = IMG_ADDR_W,
   parameter int                    DataWidth     = IMG_DATA_W,
   parameter int                    FramePixels   = 16384,
   parameter logic [DataWidth-1:0]  SyncByte      = IMG_SYNC,
   parameter int                    TimeoutCycles = 12000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DataWidth-1:0]    rx_data,
   input  logic                    rx_valid,
   input  logic [AddressWidth-1:0] rd_addr,
   output logic                    ram_rw,
   output logic [AddressWidth-1:0] ram_addr,
   output logic [DataWidth-1:0]    ram_data,
   output logic                    loading,
   output logic                    frame_done,
   output logic                    error
);
   localparam logic [AddressWidth-1:0] LAST_PTR = AddressWidth'(FramePixels - 1);

   state_t                  state;
   logic [AddressWidth-1:0] wr_ptr;
   logic                    sync_seen;
   logic                    to_clr;
   logic                    to_en;
   logic                    to_expired;

   assign sync_seen = (state == IDLE) && rx_valid && (rx_data == SyncByte);
   assign to_clr    = sync_seen || ((state == LOAD) && rx_valid);
   assign to_en     = (state == LOAD) && !rx_valid;

   byte_timeout #(
      .TimeoutCycles(TimeoutCycles)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (to_clr),
      .en     (to_en),
      .expired(to_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         ram_rw     <= 1'b1;
         ram_addr   <= '0;
         ram_data   <= '0;
         loading    <= 1'b0;
         frame_done <= 1'b0;
         error      <= 1'b0;
      end else begin
         // Port belongs to the VGA reader unless a byte is being written this cycle.
         ram_rw     <= 1'b1;
         ram_addr   <= rd_addr;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (sync_seen) begin
                  state   <= LOAD;
                  wr_ptr  <= '0;
                  error   <= 1'b0;
                  loading <= 1'b1;
               end
            end
            LOAD: begin
               if (rx_valid) begin
                  ram_rw   <= 1'b0;
                  ram_addr <= wr_ptr;
                  ram_data <= rx_data;
                  if (wr_ptr == LAST_PTR) begin
                     frame_done <= 1'b1;
                     loading    <= 1'b0;
                     wr_ptr     <= '0;
                     state      <= IDLE;
                  end else begin
                     wr_ptr <= wr_ptr + AddressWidth'(1);
                  end
               end else if (to_expired) begin
                  error   <= 1'b1;
                  loading <= 1'b0;
                  wr_ptr  <= '0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_img_ram_loader.sv
// Directed bench for img_ram_loader with a 4-pixel frame and a 16-cycle byte timeout.
module tb_img_ram_loader;
   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [13:0] rd_addr;
   logic        ram_rw;
   logic [13:0] ram_addr;
   logic [7:0]  ram_data;
   logic        loading;
   logic        frame_done;
   logic        error;

   int checks = 0;
   int errors = 0;

   img_ram_loader #(
      .AddressWidth (14),
      .DataWidth    (8),
      .FramePixels  (4),
      .SyncByte     (8'hAA),
      .TimeoutCycles(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rd_addr   (rd_addr),
      .ram_rw    (ram_rw),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .loading   (loading),
      .frame_done(frame_done),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one byte for exactly one rising edge; returns 1 ns after that edge.
   task automatic push(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_write(input string tag, input logic [13:0] a, input logic [7:0] d, input logic last);
      chk({tag, "_rw"}, ram_rw, 0);
      chk({tag, "_addr"}, ram_addr, a);
      chk({tag, "_data"}, ram_data, d);
      chk({tag, "_done"}, frame_done, last);
      chk({tag, "_loading"}, loading, !last);
   endtask

   initial begin
      rst      = 1'b1;
      rx_data  = '0;
      rx_valid = 1'b0;
      rd_addr  = '0;
      #12;
      chk("rst_rw", ram_rw, 1);
      chk("rst_addr", ram_addr, 0);
      chk("rst_data", ram_data, 0);
      chk("rst_loading", loading, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_error", error, 0);
      @(negedge clk);
      rst     = 1'b0;
      rd_addr = 14'd5;
      idle(1);
      chk("idle_rw", ram_rw, 1);
      chk("idle_addr", ram_addr, 5);
      chk("idle_loading", loading, 0);

      // Non-sync byte in IDLE, then a gapped frame.
      push(8'h11);
      chk("junk_rw", ram_rw, 1);
      chk("junk_loading", loading, 0);
      push(8'hAA);
      chk("sync_rw", ram_rw, 1);
      chk("sync_loading", loading, 1);
      for (int i = 0; i < 4; i++) begin
         idle(3);
         chk("gap_rw", ram_rw, 1);
         chk("gap_addr", ram_addr, 5);
         push(8'(i + 1));
         chk_write("gap_wr", 14'(i), 8'(i + 1), i == 3);
      end
      idle(1);
      chk("done_clear", frame_done, 0);
      chk("done_rw", ram_rw, 1);

      // Sync-valued pixels back to back.
      push(8'hAA);
      for (int i = 0; i < 4; i++) begin
         push(8'hAA);
         chk_write("b2b_wr", 14'(i), 8'hAA, i == 3);
      end

      // Timeout after one pixel.
      push(8'hAA);
      push(8'h01);
      chk_write("to_wr", 14'd0, 8'h01, 1'b0);
      idle(15);
      chk("to_not_yet", error, 0);
      chk("to_still_loading", loading, 1);
      idle(1);
      chk("to_error", error, 1);
      chk("to_loading", loading, 0);
      push(8'h05);
      chk("to_ignored_rw", ram_rw, 1);
      chk("to_sticky", error, 1);
      push(8'hAA);
      chk("to_cleared", error, 0);
      chk("to_reload", loading, 1);
      push(8'h07);
      chk_write("to_first", 14'd0, 8'h07, 1'b0);

      // Asynchronous reset mid-load (two pixels already written).
      push(8'h08);
      chk_write("pre_rst", 14'd1, 8'h08, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_rw", ram_rw, 1);
      chk("arst_addr", ram_addr, 0);
      chk("arst_data", ram_data, 0);
      chk("arst_loading", loading, 0);
      chk("arst_error", error, 0);
      @(negedge clk);
      rst = 1'b0;
      push(8'hAA);
      push(8'h09);
      chk_write("post_rst", 14'd0, 8'h09, 1'b0);

      // Read address pass-through while a gapped load continues.
      for (int p = 1; p < 4; p++) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rd_addr = 14'((k + p) % 4);
            @(posedge clk);
            #1;
            chk("track_rw", ram_rw, 1);
            chk("track_addr", ram_addr, (k + p) % 4);
         end
         push(8'(8'h09 + p));
         chk_write("track_wr", 14'(p), 8'(8'h09 + p), p == 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/img_ram_loader.md
Name: img_ram_loader

Overview:
- Writer side of the image RAM: accepts a byte stream from the UART receiver and drives the RAM's single port to fill the image buffer sequentially.
- A frame is a sync byte followed by FramePixels pixel bytes, written to addresses 0..FramePixels-1.
- When no write is pending, the port is handed to the VGA read address, so display continues during a load and shows a partially updated image.

Parameters:
- AddressWidth, 14: RAM address width.
- DataWidth, 8: pixel and byte width.
- FramePixels, 16384: bytes per frame; must be ≤ 2**AddressWidth and ≥ 1.
- SyncByte, 8'hAA: frame-start marker; DataWidth wide.
- TimeoutCycles, 12000000: maximum idle clk cycles between bytes inside a frame (1 s at 12 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  DataWidth  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- rd_addr  in  AddressWidth  VGA-side pixel read address.
- ram_rw  out  1  RAM read/write select: 1 = read, 0 = write.
- ram_addr  out  AddressWidth  RAM address.
- ram_data  out  DataWidth  RAM write data.
- loading  out  1  high while in LOAD.
- frame_done  out  1  one-cycle pulse when the last byte of a frame is written.
- error  out  1  sticky timeout flag.

Behaviour:
- All outputs are registered.
- Reset values: ram_rw=1, ram_addr=0, ram_data=0, loading=0, frame_done=0, error=0; state=IDLE, wr_ptr=0, timeout count=0.
- Reset is asynchronous and may occur mid-load. Affected RAM contents are left as already written; no clearing.
- Default port behaviour, every cycle with no write in progress: ram_rw<=1, ram_addr<=rd_addr. VGA read data therefore arrives 2 clk after rd_addr (1 cycle here, 1 in RAM).
- IDLE state:
  - rx_valid with rx_data==SyncByte: go to LOAD, wr_ptr<=0, timeout count<=0, error<=0, loading<=1.
  - Any other byte is ignored.
  - No RAM write occurs in IDLE.
- LOAD state, cycle with rx_valid:
  - ram_rw<=0, ram_addr<=wr_ptr, ram_data<=rx_data, timeout count<=0.
  - If wr_ptr==FramePixels-1: frame_done<=1, loading<=0, wr_ptr<=0, go to IDLE.
  - Otherwise wr_ptr<=wr_ptr+1.
  - The frame_done pulse coincides with the cycle the last write is presented on the port.
  - A byte equal to SyncByte inside LOAD is pixel data; there is no escaping and no resync.
- LOAD state, cycle without rx_valid:
  - Default read pass-through; timeout count increments.
  - When the count reaches TimeoutCycles-1: error<=1, loading<=0, wr_ptr<=0, go to IDLE.
  - error stays set until the next accepted sync byte.
- frame_done is cleared the cycle after it is asserted.
- Timing rules:
  - Back-to-back rx_valid (every cycle) is supported: one write per cycle and VGA reads are starved for that span.
  - The sync byte and the first pixel may be on consecutive cycles.
- Width rules:
  - wr_ptr is AddressWidth bits.
  - The timeout counter is $clog2(TimeoutCycles) bits, saturating; it does not wrap.

Decomposition:
- Shared package img_pkg holds:
  - the state enum (IDLE, LOAD);
  - default constants IMG_ADDR_W=14, IMG_DATA_W=8, IMG_SYNC=8'hAA.
- One sub-module, byte_timeout: a clear/enable counter with a one-cycle expired output, parameterised by TimeoutCycles.

Test Plan:
All scenarios use FramePixels=4 and TimeoutCycles=16.
- Reset then idle, rd_addr=5 -> ram_rw=1 and ram_addr=5 one cycle later; loading=0; no writes.
- Bytes 0x11, then 0xAA, 0x01, 0x02, 0x03, 0x04 (gapped 3 cycles) -> 0x11 ignored; writes to addr 0..3 with data 01..04; frame_done pulses with the addr-3 write; loading falls in the same cycle; ram_rw=1 between writes with ram_addr=rd_addr.
- 0xAA followed by 0xAA,0xAA,0xAA,0xAA on consecutive cycles -> four writes of 0xAA to addr 0..3 on four consecutive cycles, then frame_done.
- 0xAA, 0x01, then no bytes for 16 cycles -> error=1, back to IDLE. A subsequent 0x05 is not written. A subsequent 0xAA clears error, and the next byte is written to addr 0.
- rst asserted asynchronously after two pixels of a load -> all outputs return to reset values immediately; the following 0xAA, 0x09 writes 0x09 to addr 0.
- rd_addr toggling 0..3 during an idle-gapped load -> on non-write cycles ram_addr tracks rd_addr delayed by one cycle.
